// File: rtl/pitch_glide_control_pkg.sv
// Shared types and register map for the pitch glide controller.
package pitch_glide_control_pkg;

   typedef enum logic [1:0] {
      SNAP  = 2'd0,
      GLIDE = 2'd1,
      HOLD  = 2'd2
   } glide_state_t;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_EXP  = 2'd1,
      MODE_LIN  = 2'd2,
      MODE_RSVD = 2'd3
   } glide_mode_t;

   localparam int unsigned GLIDE_RATE_OFS = 10;
   localparam int unsigned GLIDE_MODE_OFS = 11;
   localparam logic [6:0]  LEGATO_ADR     = 7'h70;

endpackage

// File: rtl/pitch_glide_control_if.sv
// Slot, note-event, register and result signals of the pitch glide controller.
interface pitch_glide_control_if #(
   parameter int unsigned VOICES  = 8,
   parameter int unsigned V_WIDTH = 3,
   parameter int unsigned O_WIDTH = 2,
   parameter int unsigned PW      = 24
);
   logic                       slot_valid;
   logic [V_WIDTH+O_WIDTH-1:0] slot_idx;
   logic [PW-1:0]              target_pitch;
   logic                       note_on;
   logic [V_WIDTH-1:0]         note_voice;
   logic [VOICES-1:0]          key_held;
   logic                       write;
   logic                       glide_sel;
   logic [6:0]                 adr;
   logic [7:0]                 synth_data_in;
   logic [7:0]                 data_out;
   logic                       out_valid;
   logic [V_WIDTH+O_WIDTH-1:0] out_slot;
   logic [PW-1:0]              glide_pitch;
   logic [VOICES-1:0]          glide_busy;

   modport master (
      output slot_valid, slot_idx, target_pitch, note_on, note_voice, key_held,
      output write, glide_sel, adr, synth_data_in,
      input  data_out, out_valid, out_slot, glide_pitch, glide_busy
   );

   modport slave (
      input  slot_valid, slot_idx, target_pitch, note_on, note_voice, key_held,
      input  write, glide_sel, adr, synth_data_in,
      output data_out, out_valid, out_slot, glide_pitch, glide_busy
   );
endinterface

// File: rtl/pitch_glide_control_step.sv
// Combinational per-slot glide calculator: next cur_pitch and state for one visit.
// Linear mode exists only when PITCH_GLIDE_LINEAR_EN is defined; otherwise mode 2 is exponential.
module glide_step
   import pitch_glide_control_pkg::*;
#(
   parameter int unsigned PW     = 24,
   parameter int unsigned RATE_W = 5
) (
   input  logic [PW-1:0]     cur_i,
   input  logic [PW-1:0]     target_i,
   input  logic [RATE_W-1:0] rate_i,
   input  glide_mode_t       mode_i,
   input  glide_state_t      state_i,
   input  logic              pend_i,
   input  logic              legato_snap_i,
   output logic [PW-1:0]     cur_o,
   output glide_state_t      state_o
);

   logic signed [PW:0] diff;
   logic signed [PW:0] exp_step;
   logic        [PW:0] mag;
   logic        [PW:0] lin_step;
   logic               big_rate;
   logic               off_mode;
   logic               lin_mode;

`ifdef PITCH_GLIDE_LINEAR_EN
   assign lin_mode = (mode_i == MODE_LIN);
`else
   assign lin_mode = 1'b0;
`endif

   assign off_mode = (mode_i == MODE_OFF) || (mode_i == MODE_RSVD);
   assign diff     = $signed({1'b0, target_i}) - $signed({1'b0, cur_i});
   assign exp_step = diff >>> rate_i;
   assign mag      = diff[PW] ? $unsigned(-diff) : $unsigned(diff);
   assign lin_step = {{PW{1'b0}}, 1'b1} << rate_i;
   // A step of 2^PW or more always covers the remaining distance.
   assign big_rate = (int'(rate_i) >= int'(PW));

   always_comb begin
      cur_o   = cur_i;
      state_o = state_i;
      if (state_i == SNAP || (pend_i && (off_mode || legato_snap_i))) begin
         cur_o   = target_i;
         state_o = HOLD;
      end else if (pend_i) begin
         state_o = GLIDE;
      end else if (state_i == GLIDE) begin
         if (off_mode) begin
            cur_o   = target_i;
            state_o = HOLD;
         end else if (lin_mode) begin
            if (big_rate || mag <= lin_step) begin
               cur_o   = target_i;
               state_o = HOLD;
            end else if (diff[PW]) begin
               cur_o = cur_i - lin_step[PW-1:0];
            end else begin
               cur_o = cur_i + lin_step[PW-1:0];
            end
         end else if (exp_step == '0) begin
            cur_o   = target_i;
            state_o = HOLD;
         end else begin
            cur_o = cur_i + exp_step[PW-1:0];
         end
      end else begin
         cur_o   = target_i;
         state_o = HOLD;
      end
   end

endmodule

// File: rtl/pitch_glide_control.sv
// Two-stage per-slot pitch glide engine with register bank and legato handling.
// Linear glide mode is enabled by defining PITCH_GLIDE_LINEAR_EN.
module pitch_glide_control
   import pitch_glide_control_pkg::*;
#(
   parameter int unsigned VOICES  = 8,
   parameter int unsigned V_OSC   = 4,
   parameter int unsigned V_WIDTH = 3,
   parameter int unsigned O_WIDTH = 2,
   parameter int unsigned PW      = 24,
   parameter int unsigned RATE_W  = 5
) (
   input logic sCLK_XVXOSC,
   input logic reset_data,
   pitch_glide_control_if.slave bus
);

   localparam int unsigned SLOTS = VOICES * V_OSC;
   localparam int unsigned SW    = V_WIDTH + O_WIDTH;

   logic [RATE_W-1:0] rate_q [V_OSC];
   logic [1:0]        mode_q [V_OSC];
   logic              legato_q;
   logic [SLOTS-1:0]  pending_q, pending_d;
   logic              wr_en;
   logic [7:0]        rd_data;
   logic [O_WIDTH-1:0] in_osc;
   logic [V_WIDTH-1:0] in_voice;

   logic              s1_valid_q;
   logic [SW-1:0]     s1_idx_q;
   logic [PW-1:0]     s1_target_q;
   logic              s1_pend_q;
   logic              s1_lsnap_q;
   logic [RATE_W-1:0] s1_rate_q;
   glide_mode_t       s1_mode_q;

   logic [PW-1:0]     cur_q   [SLOTS];
   glide_state_t      state_q [SLOTS];
   logic [PW-1:0]     nxt_cur;
   glide_state_t      nxt_state;

   logic              out_valid_q;
   logic [SW-1:0]     out_slot_q;
   logic [PW-1:0]     out_pitch_q;
   logic [VOICES-1:0] busy;

   assign in_osc   = bus.slot_idx[O_WIDTH-1:0];
   assign in_voice = bus.slot_idx[SW-1:O_WIDTH];
   assign wr_en    = bus.glide_sel & bus.write;

   always_ff @(posedge sCLK_XVXOSC or posedge reset_data) begin
      if (reset_data) begin
         for (int o = 0; o < V_OSC; o++) begin
            rate_q[o] <= RATE_W'(4);
            mode_q[o] <= 2'd0;
         end
         legato_q <= 1'b0;
      end else if (wr_en) begin
         for (int o = 0; o < V_OSC; o++) begin
            if (bus.adr == 7'(GLIDE_RATE_OFS + 16 * o)) rate_q[o] <= bus.synth_data_in[RATE_W-1:0];
            if (bus.adr == 7'(GLIDE_MODE_OFS + 16 * o)) mode_q[o] <= bus.synth_data_in[1:0];
         end
         if (bus.adr == LEGATO_ADR) legato_q <= bus.synth_data_in[0];
      end
   end

   always_comb begin
      rd_data = '0;
      if (bus.glide_sel) begin
         if (bus.adr == LEGATO_ADR) rd_data = {7'd0, legato_q};
         for (int o = 0; o < V_OSC; o++) begin
            if (bus.adr == 7'(GLIDE_RATE_OFS + 16 * o)) rd_data = 8'(rate_q[o]);
            if (bus.adr == 7'(GLIDE_MODE_OFS + 16 * o)) rd_data = {6'd0, mode_q[o]};
         end
      end
   end
   assign bus.data_out = rd_data;

   // Pending is consumed on acceptance; a note_on in that same cycle survives for the next visit.
   always_comb begin
      pending_d = pending_q;
      if (bus.slot_valid) pending_d[bus.slot_idx] = 1'b0;
      if (bus.note_on) pending_d[{bus.note_voice, {O_WIDTH{1'b0}}} +: V_OSC] = '1;
   end

   always_ff @(posedge sCLK_XVXOSC or posedge reset_data) begin
      if (reset_data) begin
         pending_q   <= '0;
         s1_valid_q  <= 1'b0;
         s1_idx_q    <= '0;
         s1_target_q <= '0;
         s1_pend_q   <= 1'b0;
         s1_lsnap_q  <= 1'b0;
         s1_rate_q   <= '0;
         s1_mode_q   <= MODE_OFF;
      end else begin
         pending_q  <= pending_d;
         s1_valid_q <= bus.slot_valid;
         if (bus.slot_valid) begin
            s1_idx_q    <= bus.slot_idx;
            s1_target_q <= bus.target_pitch;
            s1_pend_q   <= pending_q[bus.slot_idx];
            s1_lsnap_q  <= legato_q & ~bus.key_held[in_voice];
            s1_rate_q   <= rate_q[in_osc];
            s1_mode_q   <= glide_mode_t'(mode_q[in_osc]);
         end
      end
   end

   // Slot state is written on the same edge the following stage-2 read begins, so a
   // back-to-back visit of the same slot always reads the freshly computed value.
   glide_step #(
      .PW     (PW),
      .RATE_W (RATE_W)
   ) u_step (
      .cur_i         (cur_q[s1_idx_q]),
      .target_i      (s1_target_q),
      .rate_i        (s1_rate_q),
      .mode_i        (s1_mode_q),
      .state_i       (state_q[s1_idx_q]),
      .pend_i        (s1_pend_q),
      .legato_snap_i (s1_lsnap_q),
      .cur_o         (nxt_cur),
      .state_o       (nxt_state)
   );

   always_ff @(posedge sCLK_XVXOSC or posedge reset_data) begin
      if (reset_data) begin
         for (int i = 0; i < SLOTS; i++) begin
            cur_q[i]   <= '0;
            state_q[i] <= SNAP;
         end
         out_valid_q <= 1'b0;
         out_slot_q  <= '0;
         out_pitch_q <= '0;
      end else begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            cur_q[s1_idx_q]   <= nxt_cur;
            state_q[s1_idx_q] <= nxt_state;
            out_slot_q        <= s1_idx_q;
            out_pitch_q       <= nxt_cur;
         end
      end
   end

   always_comb begin
      busy = '0;
      for (int v = 0; v < VOICES; v++) begin
         for (int o = 0; o < V_OSC; o++) begin
            if (state_q[v * V_OSC + o] == GLIDE) busy[v] = 1'b1;
         end
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_slot    = out_slot_q;
   assign bus.glide_pitch = out_pitch_q;
   assign bus.glide_busy  = busy;

endmodule

// File: tb/tb_pitch_glide_control.sv
// Randomized bench for pitch_glide_control with an in-bench behavioural glide model.
module tb_pitch_glide_control;
   import pitch_glide_control_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pitch_glide_control_if bus ();

   pitch_glide_control dut (
      .sCLK_XVXOSC (clk),
      .reset_data  (rst),
      .bus         (bus)
   );

   typedef struct {
      int         due;
      int         slot;
      int         pitch;
      logic [7:0] busy;
   } exp_t;

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   bit           cmp_en = 0;
   exp_t         expq[$];
   int           m_cur  [32];
   glide_state_t m_st   [32];
   bit           m_pend [32];
   int           m_rate [4];
   int           m_mode [4];
   bit           m_leg;
   logic [7:0]   m_busy_vis;
   int           reg_adrs [9] = '{10, 11, 26, 27, 42, 43, 58, 59, 'h70};
   int           pool [8] = '{0, 'h1000, 'h10000, 'h3800, 'h7FFFFF, 'hFFFFFF, 1, 'h123456};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_cur[i]  = 0;
         m_st[i]   = SNAP;
         m_pend[i] = 0;
      end
      for (int o = 0; o < 4; o++) begin
         m_rate[o] = 4;
         m_mode[o] = 0;
      end
      m_leg = 0;
      m_busy_vis = '0;
      expq.delete();
   endfunction

   function automatic int model_rd(bit gs, int a);
      if (!gs) return 0;
      if (a == 'h70) return int'(m_leg);
      for (int o = 0; o < 4; o++) begin
         if (a == 10 + 16 * o) return m_rate[o];
         if (a == 11 + 16 * o) return m_mode[o];
      end
      return 0;
   endfunction

   function automatic void model_wr(int a, int d);
      if (a == 'h70) m_leg = d[0];
      for (int o = 0; o < 4; o++) begin
         if (a == 10 + 16 * o) m_rate[o] = d & 31;
         if (a == 11 + 16 * o) m_mode[o] = d & 3;
      end
   endfunction

   // One visit of slot s, applied in acceptance order; the result is due two cycles later.
   function automatic void model_slot(int s, int tgt, logic [7:0] kh);
      int v = s / 4;
      int o = s % 4;
      int md = m_mode[o];
      bit pend = m_pend[s];
      bit off = (md == 0) || (md == 3);
      bit lin = 0;
      bit snap = 0;
      int d;
      longint stp;
      logic [7:0] b = '0;
`ifdef PITCH_GLIDE_LINEAR_EN
      lin = (md == 2);
`endif
      if (m_st[s] == SNAP || (pend && (off || (m_leg && !kh[v])))) snap = 1;
      else if (pend) m_st[s] = GLIDE;
      else if (m_st[s] == GLIDE) begin
         d = tgt - m_cur[s];
         if (off) snap = 1;
         else if (lin) begin
            stp = longint'(1) << m_rate[o];
            if (longint'(d < 0 ? -d : d) <= stp) snap = 1;
            else m_cur[s] = m_cur[s] + (d > 0 ? int'(stp) : -int'(stp));
         end else begin
            d = d >>> m_rate[o];
            if (d == 0) snap = 1;
            else m_cur[s] = m_cur[s] + d;
         end
      end else snap = 1;
      if (snap) begin
         m_cur[s] = tgt;
         m_st[s]  = HOLD;
      end
      m_pend[s] = 0;
      for (int i = 0; i < 32; i++) if (m_st[i] == GLIDE) b[i / 4] = 1'b1;
      expq.push_back('{cyc + 2, s, m_cur[s], b});
   endfunction

   // Called #1 after a rising edge; returns #1 after the next rising edge.
   task automatic drive_cycle(input bit sv, input int s, input int tgt, input bit non, input int nv,
                              input logic [7:0] kh, input bit wr, input bit gs, input int a,
                              input int wd);
      bus.slot_valid    = sv;
      bus.slot_idx      = 5'(s);
      bus.target_pitch  = 24'(tgt);
      bus.note_on       = non;
      bus.note_voice    = 3'(nv);
      bus.key_held      = kh;
      bus.write         = wr;
      bus.glide_sel     = gs;
      bus.adr           = 7'(a);
      bus.synth_data_in = 8'(wd);
      #1;
      chk("data_out", bus.data_out, model_rd(gs, a));
      if (sv) model_slot(s, tgt, kh);
      if (non) for (int o = 0; o < 4; o++) m_pend[nv * 4 + o] = 1;
      if (gs && wr) model_wr(a, wd);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive_cycle(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
   endtask

   task automatic wreg(input int a, input int d);
      drive_cycle(0, 0, 0, 0, 0, 8'h00, 1, 1, a, d);
   endtask

   task automatic note(input int v);
      drive_cycle(0, 0, 0, 1, v, 8'h00, 0, 0, 0, 0);
   endtask

   // Presents one slot and waits until its result is on the outputs.
   task automatic visit(input int s, input int tgt, input logic [7:0] kh);
      drive_cycle(1, s, tgt, 0, 0, kh, 0, 0, 0, 0);
      idle();
   endtask

   task automatic do_reset();
      bus.slot_valid = 0;
      bus.note_on    = 0;
      bus.write      = 0;
      bus.glide_sel  = 0;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_slot", bus.out_slot, 0);
      chk("rst_glide_pitch", bus.glide_pitch, 0);
      chk("rst_glide_busy", bus.glide_busy, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && cmp_en) begin
         if (expq.size() > 0 && expq[0].due == cyc) begin
            chk("out_valid", bus.out_valid, 1);
            chk("out_slot", bus.out_slot, expq[0].slot);
            chk("glide_pitch", bus.glide_pitch, expq[0].pitch);
            m_busy_vis = expq[0].busy;
            void'(expq.pop_front());
         end else begin
            chk("out_valid_idle", bus.out_valid, 0);
         end
         chk("glide_busy", bus.glide_busy, m_busy_vis);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      bit sv, non, wr, gs;
      int s, tgt, a, wd;
      drive_cycle_init : begin
         bus.slot_valid = 0; bus.slot_idx = '0; bus.target_pitch = '0; bus.note_on = 0;
         bus.note_voice = '0; bus.key_held = '0; bus.write = 0; bus.glide_sel = 0;
         bus.adr = '0; bus.synth_data_in = '0;
      end
      model_reset();
      #6;
      do_reset();
      cmp_en = 1;

      // Power-up snap.
      visit(0, 'h010000, 8'h00);
      chk("pwr_snap", bus.glide_pitch, 'h010000);

      // Exponential glide on slot 0.
      wreg(10, 2);
      wreg(11, 1);
      note(0);
      visit(0, 'h020000, 8'h00);
      chk("exp_keep", bus.glide_pitch, 'h010000);
      chk("exp_busy_on", bus.glide_busy[0], 1);
      visit(0, 'h020000, 8'h00);
      chk("exp_1", bus.glide_pitch, 'h014000);
      visit(0, 'h020000, 8'h00);
      chk("exp_2", bus.glide_pitch, 'h017000);
      visit(0, 'h020000, 8'h00);
      chk("exp_3", bus.glide_pitch, 'h019400);
      for (int i = 0; i < 40 && m_st[0] == GLIDE; i++) visit(0, 'h020000, 8'h00);
      chk("exp_final", bus.glide_pitch, 'h020000);
      chk("exp_busy_off", bus.glide_busy[0], 0);

      // Back-to-back visits of slot 5.
      wreg(26, 2);
      wreg(27, 1);
      visit(5, 'h1000, 8'h00);
      note(1);
      drive_cycle(1, 5, 'h9000, 0, 0, 8'h00, 0, 0, 0, 0);
      drive_cycle(1, 5, 'h9000, 0, 0, 8'h00, 0, 0, 0, 0);
      chk("b2b_0", bus.glide_pitch, 'h1000);
      drive_cycle(1, 5, 'h9000, 0, 0, 8'h00, 0, 0, 0, 0);
      chk("b2b_1", bus.glide_pitch, 'h3000);
      idle();
      chk("b2b_2", bus.glide_pitch, 'h4800);

      // Legato on voice 2.
      wreg('h70, 1);
      visit(8, 'h100, 8'h00);
      note(2);
      visit(8, 'h8100, 8'h00);
      chk("legato_snap", bus.glide_pitch, 'h8100);
      chk("legato_snap_busy", bus.glide_busy[2], 0);
      note(2);
      visit(8, 'h100, 8'h04);
      chk("legato_glide", bus.glide_pitch, 'h8100);
      chk("legato_glide_busy", bus.glide_busy[2], 1);
      visit(8, 'h100, 8'h04);
      chk("legato_step", bus.glide_pitch, 'h6100);
      wreg('h70, 0);

`ifdef PITCH_GLIDE_LINEAR_EN
      wreg(42, 12);
      wreg(43, 2);
      visit(2, 'h1000, 8'h00);
      note(0);
      visit(2, 'h3800, 8'h00);
      chk("lin_keep", bus.glide_pitch, 'h1000);
      visit(2, 'h3800, 8'h00);
      chk("lin_1", bus.glide_pitch, 'h2000);
      visit(2, 'h3800, 8'h00);
      chk("lin_2", bus.glide_pitch, 'h3000);
      visit(2, 'h3800, 8'h00);
      chk("lin_3", bus.glide_pitch, 'h3800);
      visit(2, 'h3800, 8'h00);
      chk("lin_hold", bus.glide_pitch, 'h3800);
      chk("lin_busy_off", bus.glide_busy[0], 0);
`endif

      // Reset in the middle of a glide, with a slot in flight.
      note(0);
      visit(0, 'h100000, 8'h00);
      visit(0, 'h100000, 8'h00);
      chk("pre_rst_step", bus.glide_pitch, 'h058000);
      drive_cycle(1, 0, 'h100000, 0, 0, 8'h00, 0, 0, 0, 0);
      do_reset();
      visit(0, 'h5555, 8'h00);
      chk("post_rst_snap", bus.glide_pitch, 'h5555);
      chk("post_rst_busy", bus.glide_busy, 0);

      // Randomized traffic.
      prev = 0;
      for (int n = 0; n < 3000; n++) begin
         sv  = ($urandom_range(0, 9) < 7);
         s   = ($urandom_range(0, 3) == 0) ? prev : int'($urandom_range(0, 31));
         tgt = ($urandom_range(0, 5) == 0) ? int'($urandom & 32'hFFFFFF) : pool[$urandom_range(0, 7)];
         non = ($urandom_range(0, 7) == 0);
         wr  = ($urandom_range(0, 15) == 0);
         gs  = wr ? 1'b1 : 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                           : reg_adrs[$urandom_range(0, 8)];
         wd  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 255));
         if (sv) prev = s;
         drive_cycle(sv, s, tgt, non, int'($urandom_range(0, 7)), 8'($urandom), wr, gs, a, wd);
      end
      idle();
      idle();
      idle();
      chk("drain", expq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pitch_glide_control.md
PITCH_GLIDE_CONTROL -- requirements
Module: pitch_glide_control

Interface
REQ-001 Parameters SHALL be: VOICES 8 (voice count); V_OSC 4 (oscillators per voice); V_WIDTH 3 (voice index width); O_WIDTH 2 (oscillator index width); PW 24 (pitch increment width); RATE_W 5 (glide shift width).
REQ-002 One clock and one reset SHALL be used. The clock is sCLK_XVXOSC. Reset is reset_data, which is asynchronous and active-high.
REQ-003 Ports, in order name / direction / width / meaning:
- sCLK_XVXOSC  in  1  system clock
- reset_data  in  1  async active-high reset
- slot_valid  in  1  slot_idx/target_pitch are valid this cycle
- slot_idx  in  V_WIDTH+O_WIDTH  {voice, osc}, voice in the MSBs
- target_pitch  in  PW  destination increment, unsigned
- note_on  in  1  single-cycle note event
- note_voice  in  V_WIDTH  voice addressed by note_on
- key_held  in  VOICES  per-voice held flag, used for legato
- write  in  1  register write strobe
- glide_sel  in  1  register bank select
- adr  in  7  register address
- synth_data_in  in  8  write data
- data_out  out  8  read data, combinational from adr
- out_valid  out  1  glide_pitch is valid
- out_slot  out  V_WIDTH+O_WIDTH  slot index of the output
- glide_pitch  out  PW  glided increment
- glide_busy  out  VOICES  voice has at least one oscillator in GLIDE

Function
REQ-004 Per-oscillator registers SHALL be:
- adr 10+(o<<4): rate, low RATE_W bits used
- adr 11+(o<<4): mode, bits[1:0]: 0 off, 1 exponential, 2 linear, 3 treated as off
Common register at adr 0x70: bit0 legato_en.
Writes take effect when glide_sel && write is high on the clock edge.
REQ-005 data_out SHALL return the addressed register when glide_sel is high, and 0 otherwise.
REQ-006 The pipeline SHALL have 2 stages. A slot presented at cycle n SHALL appear on out_valid/out_slot/glide_pitch at cycle n+2, with one result per accepted slot.
REQ-007 Each slot SHALL hold state in {SNAP, GLIDE, HOLD} plus a cur_pitch register of PW bits. After reset every slot is SNAP.
REQ-008 note_on SHALL set pending[note_voice][*] for all oscillators of that voice. pending is cleared when the slot is processed.
REQ-009 Slot processing rules:
- SNAP, or pending with mode off: cur=target, go to HOLD.
- pending with legato_en=1 and key_held[v]=0: snap.
- Otherwise pending: go to GLIDE, keeping cur.
REQ-010 GLIDE, exponential mode: d = target−cur (signed PW+1 bits); cur += d>>>rate. If the shifted step is 0, cur=target and the slot goes to HOLD.
REQ-011 GLIDE, linear mode: step = 1<<rate. If |d| ≤ step, cur=target and the slot goes to HOLD. Otherwise cur moves by step toward target.
REQ-012 HOLD: cur SHALL track target each visit, so pitch bend passes through without glide.
REQ-013 Timing of note events:
- A note_on arriving in the same cycle the slot is processed takes effect on the next visit.
- A second note_on during GLIDE retargets from the current cur.
REQ-014 The same slot accepted on consecutive cycles SHALL see forwarded stage-2 state, never stale state.
REQ-015 A mode or rate write mid-GLIDE SHALL apply on the next visit. A mode change to off SHALL snap.
REQ-016 glide_busy[v] SHALL be high while any oscillator of voice v is in GLIDE, and is updated with the stage-2 result.

Reset
REQ-017 Reset SHALL set:
- outputs: out_valid=0, out_slot=0, glide_pitch=0, glide_busy=0
- per-slot state: all slots SNAP, cur=0, pending=0
- registers: rate=4, mode=0, legato_en=0
REQ-018 Reset asserted mid-glide SHALL abort all pipeline contents. No out_valid may be produced in the cycle after reset deasserts.

Configuration
REQ-019 Macro PITCH_GLIDE_LINEAR_EN controls linear mode:
- Defined: linear mode (mode 2) is available.
- Undefined: mode 2 behaves as exponential, and the mode register reads back its written value.

Structure
REQ-020 A shared package SHALL hold:
- the glide_state_t enum {SNAP, GLIDE, HOLD}
- the glide_mode_t enum
- register offset constants GLIDE_RATE_OFS=10 and GLIDE_MODE_OFS=11, and common address LEGATO_ADR=0x70
REQ-021 One sub-module SHALL be glide_step: a combinational step/next-state calculator taking cur, target, rate and mode.
REQ-022 Slot state SHALL be held in arrays indexed by slot_idx, one per VOICES*V_OSC slot.

Verification
REQ-023 Power-up: reset, then slot 0 presented with target 0x010000 → glide_pitch=0x010000 at n+2.
REQ-024 Exponential glide: mode 1, rate 2, cur 0x010000, note_on, target 0x020000 → successive visits give 0x014000, 0x017000, 0x019400, …, ending at exactly 0x020000 with glide_busy cleared.
REQ-025 Linear glide: mode 2, rate 12, cur 0x001000, note_on, target 0x003800 → 0x002000, 0x003000, 0x003800, then HOLD.
REQ-026 Legato: legato_en=1, key_held[v]=0 on note_on → immediate snap to target with no GLIDE. key_held[v]=1 → glide.
REQ-027 Back-to-back slot 5 in cycles n and n+1 during GLIDE → the n+1 result uses the n result as cur.
REQ-028 Reset asserted in the middle of a glide → all outputs 0 within the reset cycle, and the next visit snaps.
